// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl
//   Command sequencer that sits in front of a WIDTH-bit universal shift
//   register. Takes one LOAD/SHL/SHR/ROL/ROR command (with a repeat count)
//   over a valid/ready handshake. It then drives the register's mode, parallel
//   data and serial-fill inputs for the required number of cycles, and pulses
//   done at the end.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_op                   0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5-7 illegal
//   cmd_count                shift/rotate step count (ignored for LOAD)
//   cmd_data, cmd_fill       load value / serial fill bit for SHL, SHR
//   q_fb                     register contents, used as rotate feedback
//   mode, data_out           register mode (00 hold,01 SHL,10 SHR,11 load), data_in
//   serial_left/right        register serial inputs
//   busy, done, err          status; err is only meaningful while done=1
module usr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_fb,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_left,
    output logic             serial_right,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SHL  = 2'b01;
    localparam logic [1:0] M_SHR  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_HOLD;
            data_q  <= '0;
            fill_q  <= 1'b0;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        fill_d  = fill_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    fill_d = cmd_fill;
                    data_d = cmd_data;
                    err_d  = 1'b0;
                    if (cmd_op > OP_ROR) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (cmd_op != OP_LOAD && cmd_count == '0) begin
                        // Zero-step shift/rotate: complete without touching the register.
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                        unique case (cmd_op)
                            OP_LOAD:        mode_d = M_LOAD;
                            OP_SHL, OP_ROL: mode_d = M_SHL;
                            default:        mode_d = M_SHR;
                        endcase
                        cnt_d = (cmd_op == OP_LOAD) ? '0 : cmd_count - CNT_W'(1);
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    mode_d  = M_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                mode_d  = M_HOLD;
            end
        endcase
    end

    // Reset must stop shifting in the very cycle it is asserted, so mode is
    // forced to hold combinationally rather than waiting for the reset edge.
    assign mode      = (state_q == S_EXEC && !rst) ? mode_q : M_HOLD;
    assign data_out  = data_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_DONE) && err_q;

    // Rotates close the loop through the register's own output.
    always_comb begin
        serial_left  = 1'b0;
        serial_right = 1'b0;
        unique case (op_q)
            OP_SHL:  serial_left  = fill_q;
            OP_SHR:  serial_right = fill_q;
            OP_ROL:  serial_left  = q_fb[WIDTH-1];
            OP_ROR:  serial_right = q_fb[0];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_count;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic [3:0] q_fb;
    logic [1:0] mode;
    logic [3:0] data_out;
    logic       serial_left, serial_right, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
        .cmd_fill(cmd_fill), .q_fb(q_fb), .mode(mode), .data_out(data_out),
        .serial_left(serial_left), .serial_right(serial_right),
        .busy(busy), .done(done), .err(err)
    );

    // Downstream universal shift register. It has its own clear so that the
    // sequencer's reset can be shown not to disturb the stored value.
    logic       reg_clr;
    logic [3:0] q_reg;
    always_ff @(posedge clk) begin
        if (reg_clr) q_reg <= 4'b0000;
        else begin
            case (mode)
                2'b01:   q_reg <= {q_reg[2:0], serial_left};
                2'b10:   q_reg <= {serial_right, q_reg[3:1]};
                2'b11:   q_reg <= data_out;
                default: q_reg <= q_reg;
            endcase
        end
    end
    assign q_fb = q_reg;

    // Advance one clock; observations happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command; the next edge accepts it (caller is in IDLE).
    task automatic issue(input logic [2:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic fill);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reg_clr = 1'b1; cmd_valid = 1'b0;
        cmd_op = 3'd0; cmd_count = 3'd0; cmd_data = 4'h0; cmd_fill = 1'b0;
        step(); step();
        rst = 1'b0; reg_clr = 1'b0;
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=00", mode); end
        checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
        checks++; if ({cmd_ready, busy, done, err} !== 4'b1000) begin errors++; $display("FAIL reset_status got=%b exp=1000", {cmd_ready, busy, done, err}); end
    endtask

    task automatic test_load();
        issue(3'd0, 3'd0, 4'b1010, 1'b0);
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL load_mode got=%b exp=11", mode); end
        checks++; if ({cmd_ready, busy, done} !== 3'b010) begin errors++; $display("FAIL load_exec_status got=%b exp=010", {cmd_ready, busy, done}); end
        step();
        checks++; if ({mode, done, err, busy} !== 5'b00101) begin errors++; $display("FAIL load_done got=%b exp=00101", {mode, done, err, busy}); end
        checks++; if (q_reg !== 4'b1010) begin errors++; $display("FAIL load_q got=%b exp=1010", q_reg); end
        step();
        checks++; if ({cmd_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL load_idle got=%b exp=100", {cmd_ready, busy, done}); end
    endtask

    task automatic test_shl();
        issue(3'd1, 3'd2, 4'h0, 1'b1);
        checks++; if ({mode, serial_left, serial_right} !== 4'b0110) begin errors++; $display("FAIL shl_c1 got=%b exp=0110", {mode, serial_left, serial_right}); end
        step();
        checks++; if ({mode, done} !== 3'b010) begin errors++; $display("FAIL shl_c2 got=%b exp=010", {mode, done}); end
        step();
        checks++; if ({mode, done, err} !== 4'b0010) begin errors++; $display("FAIL shl_done got=%b exp=0010", {mode, done, err}); end
        checks++; if (q_reg !== 4'b1011) begin errors++; $display("FAIL shl_q got=%b exp=1011", q_reg); end
        step();
    endtask

    task automatic test_rotate();
        issue(3'd0, 3'd0, 4'b1010, 1'b0); step(); step();
        issue(3'd4, 3'd1, 4'h0, 1'b1);
        checks++; if ({mode, serial_left, serial_right} !== 4'b1000) begin errors++; $display("FAIL ror_c1 got=%b exp=1000", {mode, serial_left, serial_right}); end
        step();
        checks++; if ({done, q_reg} !== 5'b10101) begin errors++; $display("FAIL ror_done_q got=%b exp=10101", {done, q_reg}); end
        step();
        issue(3'd3, 3'd4, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (mode !== 2'b01) begin errors++; $display("FAIL rol_mode cyc=%0d got=%b exp=01", i, mode); end
            step();
        end
        checks++; if ({mode, done, q_reg} !== 7'b0010101) begin errors++; $display("FAIL rol_done_q got=%b exp=0010101", {mode, done, q_reg}); end
        step();
    endtask

    task automatic test_zero_illegal();
        issue(3'd2, 3'd0, 4'h0, 1'b1);
        checks++; if ({mode, done, err, busy} !== 5'b00101) begin errors++; $display("FAIL cnt0_done got=%b exp=00101", {mode, done, err, busy}); end
        step();
        checks++; if ({cmd_ready, done, q_reg} !== 6'b100101) begin errors++; $display("FAIL cnt0_after got=%b exp=100101", {cmd_ready, done, q_reg}); end
        issue(3'd5, 3'd3, 4'hF, 1'b1);
        checks++; if ({mode, done, err} !== 4'b0011) begin errors++; $display("FAIL illegal_done got=%b exp=0011", {mode, done, err}); end
        step();
        checks++; if ({done, err, cmd_ready, q_reg} !== 7'b0010101) begin errors++; $display("FAIL illegal_after got=%b exp=0010101", {done, err, cmd_ready, q_reg}); end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        issue(3'd0, 3'd0, 4'b1111, 1'b0); step(); step();
        issue(3'd1, 3'd7, 4'h0, 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL rstmid_mode_in_reset got=%b exp=00", mode); end
        step();
        rst = 1'b0;
        checks++; if ({mode, busy, done, cmd_ready} !== 5'b00001) begin errors++; $display("FAIL rstmid_status got=%b exp=00001", {mode, busy, done, cmd_ready}); end
        checks++; if (q_reg !== 4'b1100) begin errors++; $display("FAIL rstmid_q got=%b exp=1100", q_reg); end
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        checks++; if ({seen_done, q_reg} !== 5'b01100) begin errors++; $display("FAIL rstmid_no_done got=%b exp=01100", {seen_done, q_reg}); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_count = 3'd0; cmd_data = 4'b0011; cmd_fill = 1'b0;
        step();
        cmd_op = 3'd2; cmd_count = 3'd1; cmd_data = 4'h0; cmd_fill = 1'b1;
        checks++; if ({mode, cmd_ready} !== 3'b110) begin errors++; $display("FAIL b2b_exec got=%b exp=110", {mode, cmd_ready}); end
        step();
        checks++; if ({mode, cmd_ready, done} !== 4'b0001) begin errors++; $display("FAIL b2b_done got=%b exp=0001", {mode, cmd_ready, done}); end
        step();
        checks++; if ({cmd_ready, mode, q_reg} !== 7'b1000011) begin errors++; $display("FAIL b2b_idle got=%b exp=1000011", {cmd_ready, mode, q_reg}); end
        step();
        cmd_valid = 1'b0;
        checks++; if ({mode, serial_right} !== 3'b101) begin errors++; $display("FAIL b2b_shr got=%b exp=101", {mode, serial_right}); end
        step();
        checks++; if ({done, err, q_reg} !== 6'b101001) begin errors++; $display("FAIL b2b_final got=%b exp=101001", {done, err, q_reg}); end
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_rotate();
        test_zero_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
